muldiv_unit: RTL

//   Iterative RV32M multiply/divide engine for the execute stage of the pipelined core.
//   - Accepts one M-extension op from E and computes it over multiple cycles.
//   - Holds busy_o high while working; the hazard unit uses it to stall F/D/E.
//   - Returns the result and destination tag with a one-cycle done_o pulse, for M-stage writeback.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply, restoring divide, fixed latency.
// Optional `MULDIV_FAST_MUL_EN selects a single-cycle multiplier for the MUL* ops.
module muldiv_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_LENGTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [2:0]                 funct3_i,
    input  logic [DATA_WIDTH-1:0]      op_a_i,
    input  logic [DATA_WIDTH-1:0]      op_b_i,
    input  logic [REG_ADDR_LENGTH-1:0] rd_i,
    input  logic                       flush_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [DATA_WIDTH-1:0]      result_o,
    output logic [REG_ADDR_LENGTH-1:0] rd_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [W-1:0]               acc_q, acc_d;   // product high half / partial remainder
    logic [W-1:0]               lo_q, lo_d;     // multiplier -> product low half / dividend -> quotient
    logic [W-1:0]               b_q, b_d;       // multiplicand or divisor magnitude
    logic [2:0]                 f3_q, f3_d;
    logic                       neg_q, neg_d;
    logic                       sa_q, sa_d;
    logic                       bz_q, bz_d;
    logic [REG_ADDR_LENGTH-1:0] rdp_q, rdp_d;
    logic [W-1:0]               res_q, res_d;
    logic [REG_ADDR_LENGTH-1:0] rdo_q, rdo_d;

    // Operand conditioning at acceptance
    logic         a_signed, b_signed, a_sgn, b_sgn, is_div;
    logic [W-1:0] a_mag, b_mag;
    assign a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign a_sgn    = a_signed & op_a_i[W-1];
    assign b_sgn    = b_signed & op_b_i[W-1];
    assign a_mag    = a_sgn ? -op_a_i : op_a_i;
    assign b_mag    = b_sgn ? -op_b_i : op_b_i;
    assign is_div   = funct3_i[2];

    // One shift-add multiply step
    logic [W:0] msum;
    assign msum = {1'b0, acc_q} + {1'b0, (lo_q[0] ? b_q : {W{1'b0}})};

    // One restoring divide step; ddiff[W] set means the trial subtraction borrowed
    logic [W:0] dshift, ddiff;
    assign dshift = {acc_q, lo_q[W-1]};
    assign ddiff  = dshift - {1'b0, b_q};

    // Sign correction
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s, rem_s;
    assign prod_s = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    assign quot_s = neg_q ? -lo_q : lo_q;
    assign rem_s  = sa_q ? -acc_q : acc_q;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fa, fb, fp;
    assign fa = {{W{a_sgn}}, op_a_i};
    assign fb = {{W{b_sgn}}, op_b_i};
    assign fp = fa * fb;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        bz_d    = bz_q;
        rdp_d   = rdp_q;
        res_d   = res_q;
        rdo_d   = rdo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div) begin
                        res_d   = (funct3_i == 3'b000) ? fp[W-1:0] : fp[2*W-1:W];
                        rdo_d   = rd_i;
                        state_d = S_DONE;
                    end else
`endif
                    begin
                        acc_d   = '0;
                        lo_d    = is_div ? a_mag : b_mag;
                        b_d     = is_div ? b_mag : a_mag;
                        f3_d    = funct3_i;
                        neg_d   = a_sgn ^ b_sgn;
                        sa_d    = a_sgn;
                        bz_d    = (op_b_i == '0);
                        rdp_d   = rd_i;
                        cnt_d   = CNT_INIT;
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (f3_q[2]) begin
                        acc_d = ddiff[W] ? dshift[W-1:0] : ddiff[W-1:0];
                        lo_d  = {lo_q[W-2:0], ~ddiff[W]};
                    end else begin
                        acc_d = msum[W:1];
                        lo_d  = {msum[0], lo_q[W-1:1]};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    // Overflow (MIN/-1) needs no special path: magnitude quotient already equals MIN
                    case (f3_q)
                        3'b000:                 res_d = prod_s[W-1:0];
                        3'b001, 3'b010, 3'b011: res_d = prod_s[2*W-1:W];
                        3'b100, 3'b101:         res_d = bz_q ? {W{1'b1}} : quot_s;
                        default:                res_d = rem_s;
                    endcase
                    rdo_d   = rdp_q;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            bz_q    <= 1'b0;
            rdp_q   <= '0;
            res_q   <= '0;
            rdo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            bz_q    <= bz_d;
            rdp_q   <= rdp_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
        end
    end

    assign busy_o   = (state_q == S_ITER) || (state_q == S_FIX);
    assign done_o   = (state_q == S_DONE);
    assign result_o = res_q;
    assign rd_o     = rdo_q;

endmodule
